// File: rtl/data_mem_ctrl.sv
// Data-memory controller: CPU MEM stage to synchronous block RAM plus an MMIO window.
// Byte/half/word accesses, byte-lane write enables, load extension, and a parameterised
// RAM read latency. The pipeline is held with stall until load data is valid.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RAM_LATENCY = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FC00
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wd,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic [31:0]       mem_data_o,
    output logic              stall,
    output logic              misaligned,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       io_addr,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_wd,
    input  logic [31:0]       io_rdata,
    input  logic              io_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_IO_WAIT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic [31:0] data_q;

    logic        is_word;
    logic        is_half;
    logic        is_io;
    logic        do_store;
    logic        do_load;
    logic [3:0]  lane_we;
    logic [31:0] load_ext;

    // Size 11 behaves as a word access.
    assign is_word    = mem_size[1];
    assign is_half    = (mem_size == 2'b01);
    assign misaligned = (is_half & mem_addr[0]) | (is_word & (mem_addr[1:0] != 2'b00));
    assign is_io      = (mem_addr >= MMIO_BASE);
    // A simultaneous read and write is treated as a store only.
    assign do_store   = mem_write & ~misaligned;
    assign do_load    = mem_read & ~mem_write & ~misaligned;

    assign ram_addr = mem_addr[ADDR_W-1:2];
    assign io_addr  = mem_addr;
    assign io_wd    = mem_wd;

    // Store lane enables and lane-replicated store data.
    always_comb begin
        lane_we = 4'b0000;
        ram_din = mem_wd;
        case (mem_size)
            2'b00: begin
                lane_we = 4'b0001 << mem_addr[1:0];
                ram_din = {4{mem_wd[7:0]}};
            end
            2'b01: begin
                lane_we = mem_addr[1] ? 4'b1100 : 4'b0011;
                ram_din = {2{mem_wd[15:0]}};
            end
            default: begin
                lane_we = 4'b1111;
                ram_din = mem_wd;
            end
        endcase
    end

    // Lane select and sign/zero extension of the captured load word.
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        case (mem_addr[1:0])
            2'b00:   sel_b = data_q[7:0];
            2'b01:   sel_b = data_q[15:8];
            2'b10:   sel_b = data_q[23:16];
            default: sel_b = data_q[31:24];
        endcase
        sel_h = mem_addr[1] ? data_q[31:16] : data_q[15:0];
        case (mem_size)
            2'b00:   load_ext = {{24{~mem_unsigned & sel_b[7]}}, sel_b};
            2'b01:   load_ext = {{16{~mem_unsigned & sel_h[15]}}, sel_h};
            default: load_ext = data_q;
        endcase
    end

    // State register with latency counter and load-data capture.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (do_load && !is_io) cnt <= 2'(RAM_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) cnt <= cnt - 2'd1;
                    else             data_q <= ram_dout;
                end
                ST_IO_WAIT: begin
                    if (io_ready && !mem_write) data_q <= io_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (do_store && is_io)      state_nx = ST_IO_WAIT;
                else if (do_load && is_io)  state_nx = ST_IO_WAIT;
                else if (do_load)           state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 2'd0) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_IO_WAIT: begin
                if (io_ready) state_nx = mem_write ? ST_IDLE : ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs; everything that could start or hold an access is forced low during reset.
    always_comb begin
        stall      = 1'b0;
        ram_we     = 4'b0000;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        mem_data_o = '0;
        case (state)
            ST_IDLE: begin
                if (do_store && !is_io) ram_we = lane_we;
                stall = do_load | (do_store & is_io);
            end
            ST_WAIT: stall = 1'b1;
            ST_DONE: mem_data_o = load_ext;
            ST_IO_WAIT: begin
                io_rd = ~mem_write;
                io_wr = mem_write;
                stall = mem_write ? ~io_ready : 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            stall      = 1'b0;
            ram_we     = 4'b0000;
            io_rd      = 1'b0;
            io_wr      = 1'b0;
            mem_data_o = '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: latency-1 and latency-3 instances share one RAM model.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [31:0] mem_addr = '0, mem_wd = '0;
    logic [1:0]  mem_size = 2'b10;
    logic [31:0] io_rdata = '0;
    logic        io_ready = 1'b0;

    logic [31:0] data1, data3, din1, din3, ioa1, ioa3, iowd1, iowd3, dout1, dout3;
    logic        stall1, stall3, mis1, mis3, iord1, iord3, iowr1, iowr3;
    logic [13:0] addr1, addr3;
    logic [3:0]  we1, we3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(16), .RAM_LATENCY(1), .MMIO_BASE(32'hFFFF_FC00)) dut1 (
        .sys_clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_data_o(data1), .stall(stall1), .misaligned(mis1), .ram_addr(addr1),
        .ram_din(din1), .ram_we(we1), .ram_dout(dout1), .io_addr(ioa1), .io_rd(iord1),
        .io_wr(iowr1), .io_wd(iowd1), .io_rdata(io_rdata), .io_ready(io_ready));

    data_mem_ctrl #(.ADDR_W(16), .RAM_LATENCY(3), .MMIO_BASE(32'hFFFF_FC00)) dut3 (
        .sys_clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_data_o(data3), .stall(stall3), .misaligned(mis3), .ram_addr(addr3),
        .ram_din(din3), .ram_we(we3), .ram_dout(dout3), .io_addr(ioa3), .io_rd(iord3),
        .io_wr(iowr3), .io_wd(iowd3), .io_rdata(io_rdata), .io_ready(io_ready));

    // RAM model: written by dut1's lanes; 1-edge read port for dut1, 3-edge pipeline for dut3.
    logic [31:0] mem [0:16383];
    logic [31:0] p0, p1;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we1[i]) mem[addr1][8*i +: 8] <= din1[8*i +: 8];
        dout1 <= mem[addr1];
        p0    <= mem[addr3];
        p1    <= p0;
        dout3 <= p1;
    end

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wd;
        logic [1:0]  size;
        logic        uns;
        int          stalls;
        logic [31:0] data;
        logic [3:0]  we;
        logic [31:0] din;
        logic        chk_din;
        logic        mis;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd,
                                logic [1:0] size, logic uns, int stalls, logic [31:0] data,
                                logic [3:0] we, logic [31:0] din, logic chk_din, logic mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.size = size; v.uns = uns;
        v.stalls = stalls; v.data = data; v.we = we; v.din = din; v.chk_din = chk_din; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wd = wd; mem_size = sz; mem_unsigned = uns;
    endtask

    // Apply one request to dut1, wait for stall to drop, then score against the queued record.
    task automatic run_req(input vec_t v, input int idx);
        int   stalls;
        bit   done;
        vec_t e;
        @(posedge clk); #1;
        drive(v.rd, v.wr, v.addr, v.wd, v.size, v.uns);
        sb.push_back(v);
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall1) begin done = 1; break; end
            stalls++;
        end
        e = sb.pop_front();
        if (!done) begin
            chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
        end else begin
            chk($sformatf("v%0d_stalls", idx), stalls, e.stalls);
            chk($sformatf("v%0d_data", idx), data1, e.data);
            chk($sformatf("v%0d_we", idx), {28'd0, we1}, {28'd0, e.we});
            chk($sformatf("v%0d_mis", idx), {31'd0, mis1}, {31'd0, e.mis});
            if (e.chk_din) chk($sformatf("v%0d_din", idx), din1, e.din);
        end
    endtask

    // MMIO request on both instances; io_ready pulses in cycle ready_at (request cycle = 0).
    task automatic io_seq(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int ready_at, input int exp_stalls, input logic [31:0] exp_data);
        int stalls;
        bit done;
        @(posedge clk); #1;
        drive(~wr, wr, a, wd, 2'b10, 1'b0);
        stalls = 0;
        done   = 0;
        for (int c = 0; c < 20; c++) begin
            io_ready = (c == ready_at);
            io_rdata = (c == ready_at) ? exp_data : 32'hBAD0_BAD0;
            @(negedge clk);
            if (c == 1) begin
                chk({nm, "_strobe"}, {30'd0, iord1, iowr1}, wr ? 32'd1 : 32'd2);
                chk({nm, "_ioaddr"}, ioa1, a);
                if (wr) chk({nm, "_iowd"}, iowd1, wd);
                chk({nm, "_ram_we"}, {28'd0, we1}, 32'd0);
            end
            if (!stall1) begin done = 1; break; end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
        else begin
            chk({nm, "_stalls"}, stalls, exp_stalls);
            if (!wr) chk({nm, "_data"}, data1, exp_data);
        end
        @(posedge clk); #1;
        io_ready = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        drive(0, 0, 32'h0, 32'h0, 2'b10, 1'b0);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int stalls;
        bit done;

        vecs.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 0, 4'hF, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 1, 32'h20, 32'h80FF7F01, 2'b10, 0, 0, 0, 4'hF, 32'h80FF7F01, 1, 0));
        vecs.push_back(mk(1, 0, 32'h10, 0, 2'b10, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h23, 0, 2'b00, 0, 2, 32'hFFFFFF80, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h23, 0, 2'b00, 1, 2, 32'h00000080, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h22, 0, 2'b01, 0, 2, 32'hFFFF80FF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h22, 0, 2'b01, 1, 2, 32'h000080FF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h21, 0, 2'b00, 0, 2, 32'h0000007F, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h22, 0, 2'b00, 0, 2, 32'hFFFFFFFF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h20, 0, 2'b01, 0, 2, 32'h00007F01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h10, 0, 2'b11, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h22, 32'h00001234, 2'b01, 0, 0, 0, 4'b1100, 32'h12341234, 1, 0));
        vecs.push_back(mk(0, 1, 32'h21, 32'h000000AB, 2'b00, 0, 0, 0, 4'b0010, 32'hABABABAB, 1, 0));
        vecs.push_back(mk(1, 0, 32'h20, 0, 2'b10, 0, 2, 32'h1234AB01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h12, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h11, 32'h00001234, 2'b01, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h30, 32'h11223344, 2'b10, 0, 0, 0, 4'hF, 32'h11223344, 1, 0));
        vecs.push_back(mk(1, 0, 32'h30, 0, 2'b10, 0, 2, 32'h11223344, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h33, 32'h000000FF, 2'b00, 0, 0, 0, 4'b1000, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(1, 0, 32'h33, 0, 2'b00, 1, 2, 32'h000000FF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h31, 0, 2'b00, 0, 2, 32'h00000033, 0, 0, 0, 0));

        // Reset state: requests present while reset is held must not reach RAM or MMIO.
        drive(0, 1, 32'h40, 32'h55555555, 2'b10, 0);
        #13;
        chk("rst_we", {28'd0, we1}, 32'd0);
        chk("rst_stall_wr", {31'd0, stall1}, 32'd0);
        drive(1, 0, 32'hFFFF_FC04, 0, 2'b10, 0);
        #10;
        chk("rst_io", {30'd0, iord1, iowr1}, 32'd0);
        chk("rst_stall_rd", {30'd0, stall1, stall3}, 32'd0);
        chk("rst_data", data1, 32'd0);
        drive(0, 0, 32'h0, 32'h0, 2'b10, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], i);

        io_seq("io_rd", 1'b0, 32'hFFFF_FC04, 32'h0, 3, 4, 32'h0000005A);
        io_seq("io_wr", 1'b1, 32'hFFFF_FC08, 32'hCAFE0001, 2, 2, 32'h0);

        // Latency-3 load: four stall cycles, data in the fifth, then back in IDLE.
        idle(8);
        @(posedge clk); #1;
        drive(1, 0, 32'h10, 0, 2'b10, 0);
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall3) begin done = 1; break; end
            stalls++;
        end
        if (!done) chk("l3_timeout", 32'd1, 32'd0);
        else begin
            chk("l3_stalls", stalls, 32'd4);
            chk("l3_data", data3, 32'hDEADBEEF);
        end
        @(negedge clk);
        chk("l3_idle_restart", {31'd0, stall3}, 32'd1);
        chk("l3_idle_data", data3, 32'd0);

        // Reset in the middle of a latency-3 wait.
        idle(8);
        @(posedge clk); #1;
        drive(1, 0, 32'h10, 0, 2'b10, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_stall", {31'd0, stall3}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {30'd0, stall1, stall3}, 32'd0);
        drive(0, 0, 32'h0, 32'h0, 2'b10, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after_stall", {31'd0, stall3}, 32'd0);
        chk("mid_after_data", data3, 32'd0);
        chk("mid_after_we", {28'd0, we1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
